// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter: the encoding of the direction
// select input.
package up_down_counter_pkg;

  // Direction select encoding on mode_i.
  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// Free-running WIDTH-bit binary counter. Each rising edge either clears the
// count (rst_i high), increments it (mode_i = up) or decrements it (any
// other mode_i value). Arithmetic wraps modulo 2^WIDTH and the output comes
// straight from the count register, so there is no input-to-output
// combinational path.
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] count_o
);

  import up_down_counter_pkg::*;

  // Unit step sized to the counter so add/subtract stay WIDTH bits wide and
  // carry/borrow simply falls off the top.
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  // A zero-width counter is meaningless; stop elaboration if requested.
  if (WIDTH < 1) begin : g_width_check
    $error("up_down_counter: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-state: step up only on an explicit up code; anything else
  // (including X/Z in simulation) falls through to the down step.
  always_comb begin
    count_d = count_q;
    if (mode_i == MODE_UP) begin
      count_d = count_q + STEP;
    end else begin
      count_d = count_q - STEP;
    end
  end

  // Count register with synchronous clear taking priority over counting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter: the stimulus process drives one
// input vector per cycle and queues the hand-computed count expected after
// the next rising edge; an independent monitor pops and compares one entry
// per cycle just after each rising edge.
module tb_up_down_counter;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] count;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;

  up_down_counter #(.WIDTH(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .mode_i (mode),
    .count_o(count)
  );

  // 20-unit clock, first rising edge at t=10.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Monitor: one registered result per edge, compared 1 unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (count !== e.exp) begin
          n_fail++;
          $display("FAIL %s @%0t: count=%h required=%h", e.name, $time, count, e.exp);
        end
      end
    end
  end

  // Apply inputs 5 units after the current edge and queue the expected value
  // for the following edge.
  task automatic vec(input logic r, input logic m, input logic [3:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #5;
    rst  = r;
    mode = m;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e0;
    n_cmp  = 0;
    n_fail = 0;

    // Reset through the first edge (t=10).
    rst  = 1'b1;
    mode = 1'b0;
    e0.exp  = 4'h0;
    e0.name = "reset";
    exp_q.push_back(e0);

    // Up-count from 0: 1..F, wrap to 0, then on to 4 (20 edges).
    vec(1'b0, 1'b1, 4'h1, "up");
    vec(1'b0, 1'b1, 4'h2, "up");
    vec(1'b0, 1'b1, 4'h3, "up");
    vec(1'b0, 1'b1, 4'h4, "up");
    vec(1'b0, 1'b1, 4'h5, "up");
    vec(1'b0, 1'b1, 4'h6, "up");
    vec(1'b0, 1'b1, 4'h7, "up");
    vec(1'b0, 1'b1, 4'h8, "up");
    vec(1'b0, 1'b1, 4'h9, "up");
    vec(1'b0, 1'b1, 4'hA, "up");
    vec(1'b0, 1'b1, 4'hB, "up");
    vec(1'b0, 1'b1, 4'hC, "up");
    vec(1'b0, 1'b1, 4'hD, "up");
    vec(1'b0, 1'b1, 4'hE, "up");
    vec(1'b0, 1'b1, 4'hF, "up");
    vec(1'b0, 1'b1, 4'h0, "up_wrap");
    vec(1'b0, 1'b1, 4'h1, "up");
    vec(1'b0, 1'b1, 4'h2, "up");
    vec(1'b0, 1'b1, 4'h3, "up");
    vec(1'b0, 1'b1, 4'h4, "up");

    // Down-count from 4 through the 0 -> F wrap, stopping at 7.
    vec(1'b0, 1'b0, 4'h3, "down");
    vec(1'b0, 1'b0, 4'h2, "down");
    vec(1'b0, 1'b0, 4'h1, "down");
    vec(1'b0, 1'b0, 4'h0, "down");
    vec(1'b0, 1'b0, 4'hF, "down_wrap");
    vec(1'b0, 1'b0, 4'hE, "down");
    vec(1'b0, 1'b0, 4'hD, "down");
    vec(1'b0, 1'b0, 4'hC, "down");
    vec(1'b0, 1'b0, 4'hB, "down");
    vec(1'b0, 1'b0, 4'hA, "down");
    vec(1'b0, 1'b0, 4'h9, "down");
    vec(1'b0, 1'b0, 4'h8, "down");
    vec(1'b0, 1'b0, 4'h7, "down");

    // Direction reversal every cycle from 7.
    vec(1'b0, 1'b1, 4'h8, "reverse");
    vec(1'b0, 1'b0, 4'h7, "reverse");
    vec(1'b0, 1'b1, 4'h8, "reverse");
    vec(1'b0, 1'b0, 4'h7, "reverse");
    vec(1'b0, 1'b1, 4'h8, "reverse");

    // Mid-run reset held two edges with mode up, then release.
    vec(1'b0, 1'b1, 4'h9, "pre_reset");
    vec(1'b1, 1'b1, 4'h0, "mid_reset");
    vec(1'b1, 1'b1, 4'h0, "mid_reset_hold");
    vec(1'b0, 1'b1, 4'h1, "reset_release_up");

    // Reset with mode down, then release while counting down: 0 -> F.
    vec(1'b1, 1'b0, 4'h0, "reset_mode_down");
    vec(1'b0, 1'b0, 4'hF, "reset_release_down");
    vec(1'b0, 1'b0, 4'hE, "down");

    // Reset dominance with an unknown direction select.
    vec(1'b1, 1'bx, 4'h0, "reset_mode_x");
    vec(1'b0, 1'b1, 4'h1, "after_reset_x");
    vec(1'b0, 1'b1, 4'h2, "up");

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
